unid_acesso_mem: RTL and testbench
==================================

UNID_ACESSO_MEM -- requirements
Module: unid_acesso_mem

Interface
REQ-001 SHALL have parameter LATENCIA_LEITURA, default 1: memory-side read wait cycles, legal range 1..15.
REQ-002 SHALL have port clock  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valido  input  1  pipeline request present.
REQ-005 SHALL have port req_pronto  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_escrita  input  1  1 = store halfword, 0 = load halfword.
REQ-007 SHALL have port req_endereco  input  32  byte address.
REQ-008 SHALL have port req_dado  input  32  store data; bits [15:0] used.
REQ-009 SHALL have port resp_valido  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_dado  output  32  sign-extended load result; 0 for stores.
REQ-011 SHALL have port erro_alinhamento  output  1  one-cycle misalignment pulse (see Configuration).
REQ-012 SHALL have port mem_endereco  output  32  address to data memory.
REQ-013 SHALL have port mem_valor  output  32  write data to data memory.
REQ-014 SHALL have port mem_escrita  output  1  memory write strobe.
REQ-015 SHALL have port mem_leitura  output  1  memory read enable.
REQ-016 SHALL have port mem_dado  input  32  memory read data, already halfword-selected and sign-extended.

Function
REQ-017 SHALL implement FSM states OCIOSO, LEITURA, ESCRITA, RESPOSTA.
REQ-018 SHALL assert req_pronto only in OCIOSO; a request is accepted when req_valido && req_pronto at a rising edge.
REQ-019 SHALL register req_endereco, req_dado and req_escrita on acceptance; subsequent changes on these inputs are ignored until return to OCIOSO.
REQ-020 SHALL, on an accepted load, enter LEITURA, drive mem_leitura=1 and mem_endereco = latched address, and load the wait counter with LATENCIA_LEITURA-1.
REQ-021 SHALL decrement the counter each cycle in LEITURA; when it reaches 0, capture mem_dado into resp_dado at that edge and enter RESPOSTA.
REQ-022 SHALL, on an accepted store, enter ESCRITA for exactly one cycle, with mem_escrita=1, mem_endereco and mem_valor = {16'b0, latched data[15:0]} stable over the full cycle (covering the memory's falling-edge write), then enter RESPOSTA.
REQ-023 SHALL hold mem_escrita=0 and mem_leitura=0 in OCIOSO and RESPOSTA; mem_escrita and mem_leitura SHALL never be asserted together.
REQ-024 SHALL assert resp_valido for exactly one cycle in RESPOSTA, then return to OCIOSO; load latency from acceptance to resp_valido = LATENCIA_LEITURA+1 cycles, store latency = 2 cycles.
REQ-025 SHALL hold resp_dado stable from RESPOSTA until the next load capture; a store sets resp_dado to 0.
REQ-026 SHALL not accept a new request in RESPOSTA (no back-to-back overlap); minimum spacing between accepts = latency+1.
REQ-027 SHALL accept address wrap-around unchanged (0xFFFFFFFE is legal and passed through).

Reset
REQ-028 SHALL, while reset=1, force state OCIOSO, counter 0, req_pronto=1, resp_valido=0, resp_dado=0, erro_alinhamento=0, mem_endereco=0, mem_valor=0, mem_escrita=0, mem_leitura=0.
REQ-029 SHALL abort an in-flight access on reset mid-operation with no resp_valido produced; mem_escrita SHALL drop immediately (asynchronously).

Configuration
REQ-030 SHALL, with macro UNID_ACESSO_ALINHAMENTO_EN defined, reject any request with req_endereco[0]=1: no memory strobe, go directly to RESPOSTA with erro_alinhamento=1 and resp_valido=1 for one cycle, resp_dado unchanged.
REQ-031 SHALL, without UNID_ACESSO_ALINHAMENTO_EN, ignore req_endereco[0] (forwarded as-is), tie erro_alinhamento to 0, and perform the access normally.

Verification
REQ-032 SHALL cover: store req_endereco=0x10, req_dado=0x0000ABCD -> one cycle mem_escrita=1, mem_endereco=0x10, mem_valor=0x0000ABCD; resp_valido 2 cycles after accept, resp_dado=0.
REQ-033 SHALL cover: LATENCIA_LEITURA=3, load 0x12 with mem_dado=0xFFFF8001 -> mem_leitura high 3 cycles, resp_valido 4 cycles after accept, resp_dado=0xFFFF8001.
REQ-034 SHALL cover: req_valido held high continuously with LATENCIA_LEITURA=1 -> accepts occur every 3 cycles for loads, req_pronto=0 between.
REQ-035 SHALL cover: reset asserted in ESCRITA -> mem_escrita=0 immediately, no resp_valido, req_pronto=1 after release.
REQ-036 SHALL cover: UNID_ACESSO_ALINHAMENTO_EN defined, load 0x13 -> no mem_leitura, erro_alinhamento=1 and resp_valido=1 one cycle after accept; undefined -> normal load at 0x13, erro_alinhamento=0.

Source files
------------

// File: rtl/unid_acesso_mem.sv
// Halfword load/store access unit between the pipeline and the data memory.
// Optional misaligned-address rejection is enabled by defining UNID_ACESSO_ALINHAMENTO_EN.
module unid_acesso_mem #(
   parameter int LATENCIA_LEITURA = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valido,
   output logic        req_pronto,
   input  logic        req_escrita,
   input  logic [31:0] req_endereco,
   input  logic [31:0] req_dado,
   output logic        resp_valido,
   output logic [31:0] resp_dado,
   output logic        erro_alinhamento,
   output logic [31:0] mem_endereco,
   output logic [31:0] mem_valor,
   output logic        mem_escrita,
   output logic        mem_leitura,
   input  logic [31:0] mem_dado
);

   typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, RESPOSTA} estado_t;

   localparam logic [3:0] CONTADOR_INICIAL = 4'(LATENCIA_LEITURA - 1);

   estado_t     estado_q;
   logic [3:0]  contador_q;
   logic        req_pronto_q;
   logic        resp_valido_q;
   logic [31:0] resp_dado_q;
   logic [31:0] mem_endereco_q;
   logic [31:0] mem_valor_q;
   logic        mem_escrita_q;
   logic        mem_leitura_q;
   logic        erro_q;
   logic        desalinhado;

   // Only the low halfword of the store data reaches memory.
   logic unused_dado_alto;
   assign unused_dado_alto = ^req_dado[31:16];

`ifdef UNID_ACESSO_ALINHAMENTO_EN
   assign desalinhado      = req_endereco[0];
   assign erro_alinhamento = erro_q;
`else
   assign desalinhado      = 1'b0;
   assign erro_alinhamento = 1'b0;
`endif

   // NOTE: every strobe is a flop output, so the asynchronous reset clears
   // mem_escrita at once without waiting for a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q       <= OCIOSO;
         contador_q     <= 4'd0;
         req_pronto_q   <= 1'b1;
         resp_valido_q  <= 1'b0;
         resp_dado_q    <= 32'd0;
         mem_endereco_q <= 32'd0;
         mem_valor_q    <= 32'd0;
         mem_escrita_q  <= 1'b0;
         mem_leitura_q  <= 1'b0;
         erro_q         <= 1'b0;
      end else begin
         resp_valido_q <= 1'b0;
         erro_q        <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (req_valido && req_pronto_q) begin
                  req_pronto_q <= 1'b0;
                  if (desalinhado) begin
                     estado_q      <= RESPOSTA;
                     resp_valido_q <= 1'b1;
                     erro_q        <= 1'b1;
                  end else if (req_escrita) begin
                     estado_q       <= ESCRITA;
                     mem_endereco_q <= req_endereco;
                     mem_valor_q    <= {16'b0, req_dado[15:0]};
                     mem_escrita_q  <= 1'b1;
                  end else begin
                     estado_q       <= LEITURA;
                     mem_endereco_q <= req_endereco;
                     mem_leitura_q  <= 1'b1;
                     contador_q     <= CONTADOR_INICIAL;
                  end
               end
            end
            LEITURA: begin
               if (contador_q == 4'd0) begin
                  estado_q      <= RESPOSTA;
                  mem_leitura_q <= 1'b0;
                  resp_dado_q   <= mem_dado;
                  resp_valido_q <= 1'b1;
               end else begin
                  contador_q <= contador_q - 4'd1;
               end
            end
            ESCRITA: begin
               estado_q      <= RESPOSTA;
               mem_escrita_q <= 1'b0;
               resp_dado_q   <= 32'd0;
               resp_valido_q <= 1'b1;
            end
            RESPOSTA: begin
               estado_q     <= OCIOSO;
               req_pronto_q <= 1'b1;
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign req_pronto   = req_pronto_q;
   assign resp_valido  = resp_valido_q;
   assign resp_dado    = resp_dado_q;
   assign mem_endereco = mem_endereco_q;
   assign mem_valor    = mem_valor_q;
   assign mem_escrita  = mem_escrita_q;
   assign mem_leitura  = mem_leitura_q;

endmodule

// File: tb/tb_unid_acesso_mem.sv
// Self-checking bench for unid_acesso_mem: a LATENCIA_LEITURA=3 instance for single
// transactions and a LATENCIA_LEITURA=1 instance for continuous back-to-back loads.
module tb_unid_acesso_mem;

   localparam int LAT_A = 3;
   localparam int LAT_B = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        req_valido_a, req_escrita_a, req_pronto_a, resp_valido_a, erro_alinhamento_a;
   logic        mem_escrita_a, mem_leitura_a;
   logic [31:0] req_endereco_a, req_dado_a, resp_dado_a, mem_endereco_a, mem_valor_a, mem_dado_a;

   logic        req_valido_b, req_escrita_b, req_pronto_b, resp_valido_b, erro_alinhamento_b;
   logic        mem_escrita_b, mem_leitura_b;
   logic [31:0] req_endereco_b, req_dado_b, resp_dado_b, mem_endereco_b, mem_valor_b, mem_dado_b;

   unid_acesso_mem #(.LATENCIA_LEITURA(LAT_A)) dut_a (
      .clock(clock), .reset(reset),
      .req_valido(req_valido_a), .req_pronto(req_pronto_a), .req_escrita(req_escrita_a),
      .req_endereco(req_endereco_a), .req_dado(req_dado_a),
      .resp_valido(resp_valido_a), .resp_dado(resp_dado_a), .erro_alinhamento(erro_alinhamento_a),
      .mem_endereco(mem_endereco_a), .mem_valor(mem_valor_a), .mem_escrita(mem_escrita_a),
      .mem_leitura(mem_leitura_a), .mem_dado(mem_dado_a)
   );

   unid_acesso_mem #(.LATENCIA_LEITURA(LAT_B)) dut_b (
      .clock(clock), .reset(reset),
      .req_valido(req_valido_b), .req_pronto(req_pronto_b), .req_escrita(req_escrita_b),
      .req_endereco(req_endereco_b), .req_dado(req_dado_b),
      .resp_valido(resp_valido_b), .resp_dado(resp_dado_b), .erro_alinhamento(erro_alinhamento_b),
      .mem_endereco(mem_endereco_b), .mem_valor(mem_valor_b), .mem_escrita(mem_escrita_b),
      .mem_leitura(mem_leitura_b), .mem_dado(mem_dado_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: the load result the unit should currently be presenting.
   logic [31:0] modelo_resp_dado = 32'd0;

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      reset        = 1'b1;
      req_valido_a = 1'b0; req_escrita_a = 1'b0; req_endereco_a = 32'd0; req_dado_a = 32'd0;
      mem_dado_a   = 32'd0;
      req_valido_b = 1'b0; req_escrita_b = 1'b0; req_endereco_b = 32'd0; req_dado_b = 32'd0;
      mem_dado_b   = 32'd0;
      repeat (3) ciclo();
      obs = {req_pronto_a, resp_valido_a, erro_alinhamento_a, mem_leitura_a, mem_escrita_a};
      vectors++;
      if (obs !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 10000", obs);
      end
      vectors++;
      if ({resp_dado_a, mem_endereco_a, mem_valor_a} !== 96'd0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h expected all zero", resp_dado_a, mem_endereco_a, mem_valor_a);
      end
      reset = 1'b0;
      modelo_resp_dado = 32'd0;
      ciclo();
   endtask

   // One transaction on dut_a checked cycle by cycle against the rules: a store responds
   // in the 2nd cycle after acceptance, a load in cycle LAT_A+1, a rejected access in the 1st.
   task automatic transacao(input bit escrita, input logic [31:0] endereco, input logic [31:0] dado,
                            input logic [31:0] dado_mem, input string nome);
      int         espera;
      int         r;
      bit         desal;
      logic [4:0] obs;
      logic [4:0] esperado;
      espera = 0;
      while (req_pronto_a !== 1'b1 && espera < 40) begin
         ciclo();
         espera++;
      end
      vectors++;
      if (req_pronto_a !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_pronto: got %b expected 1 within 40 cycles", nome, req_pronto_a);
         return;
      end
`ifdef UNID_ACESSO_ALINHAMENTO_EN
      desal = endereco[0];
`else
      desal = 1'b0;
`endif
      r = desal ? 1 : (escrita ? 2 : LAT_A + 1);
      req_valido_a   = 1'b1;
      req_escrita_a  = escrita;
      req_endereco_a = endereco;
      req_dado_a     = dado;
      mem_dado_a     = $urandom;
      ciclo();
      // Scramble the request inputs; the unit must work from what it latched.
      req_valido_a   = 1'b0;
      req_escrita_a  = 1'($urandom);
      req_endereco_a = $urandom;
      req_dado_a     = $urandom;
      for (int k = 1; k <= r + 1; k++) begin
         mem_dado_a = (!escrita && !desal && k == LAT_A) ? dado_mem : $urandom;
         if (k == r)
            modelo_resp_dado = desal ? modelo_resp_dado : (escrita ? 32'd0 : dado_mem);
         esperado = {k == r + 1, k == r, desal && k == r,
                     !escrita && !desal && k < r, escrita && !desal && k == 1};
         obs = {req_pronto_a, resp_valido_a, erro_alinhamento_a, mem_leitura_a, mem_escrita_a};
         vectors++;
         if (obs !== esperado) begin
            miscompares++;
            $display("FAIL %s_ctrl c%0d: pronto/valido/erro/leit/escr got %b expected %b", nome, k, obs, esperado);
         end
         if (!desal && k < r) begin
            vectors++;
            if (mem_endereco_a !== endereco || (escrita && mem_valor_a !== {16'b0, dado[15:0]})) begin
               miscompares++;
               $display("FAIL %s_mem c%0d: end %h valor %h expected end %h valor %h", nome, k,
                        mem_endereco_a, mem_valor_a, endereco, {16'b0, dado[15:0]});
            end
         end
         if (k >= r) begin
            vectors++;
            if (resp_dado_a !== modelo_resp_dado) begin
               miscompares++;
               $display("FAIL %s_resp c%0d: got %h expected %h", nome, k, resp_dado_a, modelo_resp_dado);
            end
         end
         ciclo();
      end
   endtask

   task automatic test_store_basico();
      transacao(1'b1, 32'h0000_0010, 32'h0000_ABCD, 32'd0, "store_10");
   endtask

   task automatic test_load_latencia();
      transacao(1'b0, 32'h0000_0012, 32'd0, 32'hFFFF_8001, "load_12");
   endtask

   task automatic test_alinhamento();
      transacao(1'b0, 32'h0000_0013, 32'd0, 32'h0000_7FFF, "load_13");
      transacao(1'b1, 32'h0000_0021, 32'h5555_1234, 32'd0, "store_21");
   endtask

   task automatic test_wrap();
      transacao(1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'd0, "store_wrap");
      transacao(1'b0, 32'hFFFF_FFFE, 32'd0, 32'h0000_1234, "load_wrap");
   endtask

   task automatic test_aleatorio();
      for (int i = 0; i < 24; i++)
         transacao(1'($urandom), $urandom, $urandom, $urandom, "rand");
   endtask

   task automatic test_reset_escrita();
      logic [4:0] obs;
      req_valido_a   = 1'b1;
      req_escrita_a  = 1'b1;
      req_endereco_a = 32'h0000_0040;
      req_dado_a     = 32'h0000_7777;
      ciclo();
      req_valido_a = 1'b0;
      vectors++;
      if (mem_escrita_a !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_escr_pre: mem_escrita got %b expected 1", mem_escrita_a);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (mem_escrita_a !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_escr_async: mem_escrita got %b expected 0", mem_escrita_a);
      end
      ciclo();
      reset = 1'b0;
      modelo_resp_dado = 32'd0;
      for (int k = 0; k < 4; k++) begin
         obs = {req_pronto_a, resp_valido_a, erro_alinhamento_a, mem_leitura_a, mem_escrita_a};
         vectors++;
         if (obs !== 5'b10000 || resp_dado_a !== modelo_resp_dado) begin
            miscompares++;
            $display("FAIL rst_escr_post c%0d: ctrl %b dado %h expected 10000 %h", k, obs, resp_dado_a,
                     modelo_resp_dado);
         end
         ciclo();
      end
   endtask

   // Loads with req_valido held high on the LAT_B=1 instance: accept, read, respond, idle.
   task automatic test_back_to_back();
      logic [4:0]  obs;
      logic [4:0]  esperado;
      logic [31:0] capturado;
      logic [31:0] endereco_aceito;
      int          fase;
      capturado       = 32'd0;
      endereco_aceito = 32'd0;
      req_valido_b    = 1'b1;
      req_escrita_b   = 1'b0;
      for (int n = 0; n < 18; n++) begin
         fase           = n % 3;
         req_endereco_b = $urandom & 32'hFFFF_FFFE;
         req_dado_b     = $urandom;
         mem_dado_b     = $urandom;
         if (fase == 0) endereco_aceito = req_endereco_b;
         if (fase == 1) capturado = mem_dado_b;
         esperado = {fase == 0, fase == 2, 1'b0, fase == 1, 1'b0};
         obs = {req_pronto_b, resp_valido_b, erro_alinhamento_b, mem_leitura_b, mem_escrita_b};
         vectors++;
         if (obs !== esperado) begin
            miscompares++;
            $display("FAIL b2b_ctrl c%0d: got %b expected %b", n, obs, esperado);
         end
         if (fase == 1) begin
            vectors++;
            if (mem_endereco_b !== endereco_aceito) begin
               miscompares++;
               $display("FAIL b2b_end c%0d: got %h expected %h", n, mem_endereco_b, endereco_aceito);
            end
         end
         if (fase == 2) begin
            vectors++;
            if (resp_dado_b !== capturado) begin
               miscompares++;
               $display("FAIL b2b_resp c%0d: got %h expected %h", n, resp_dado_b, capturado);
            end
         end
         ciclo();
      end
      req_valido_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_store_basico();
      test_load_latencia();
      test_alinhamento();
      test_wrap();
      test_aleatorio();
      test_reset_escrita();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
